sdrc_init_refresh_seq: RTL and testbench

//  Sequences the SDRAM power-up initialisation (wait, PRECHARGE-ALL, N x AUTO-REFRESH, LOAD-MODE),

---
 rtl/sdrc_init_refresh_seq.sv | 177 +++++++++++++++++
 tb/tb_sdrc_init_refresh_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sdrc_init_refresh_seq.sv
// SDRAM power-up initialisation sequencer and periodic auto-refresh scheduler.
// Owns the command pins during init and for each granted refresh; all outputs are registered.
module sdrc_init_refresh_seq #(
  parameter int          PWR_UP_CYC   = 10000,
  parameter int          TRP_CYC      = 3,
  parameter int          TRFC_CYC     = 7,
  parameter int          TMRD_CYC     = 2,
  parameter int          INIT_REF     = 2,
  parameter int          REF_INTERVAL = 780,
  parameter logic [12:0] MODE_REG     = 13'h033
) (
  input  logic        sdram_clk,
  input  logic        sdram_reset,
  input  logic        ref_gnt,
  output logic        ref_req,
  output logic        cmd_own,
  output logic        sdr_cke,
  output logic        sdr_cs_n,
  output logic        sdr_ras_n,
  output logic        sdr_cas_n,
  output logic        sdr_we_n,
  output logic [1:0]  sdr_ba,
  output logic [12:0] sdr_addr,
  output logic        sdr_init_done,
  output logic        ref_overflow
);

  localparam int CNT_W = $clog2(PWR_UP_CYC + TRP_CYC + TRFC_CYC + TMRD_CYC + 1);
  localparam int RC_W  = $clog2(REF_INTERVAL + 1);
  localparam int IC_W  = $clog2(INIT_REF + 1) + 1;

  // Wait states exit two counts early: one cycle for the state register, one for the output register.
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWR_UP_CYC - 1);
  localparam logic [CNT_W-1:0] TRP_LAST   = CNT_W'((TRP_CYC  >= 2) ? TRP_CYC  - 2 : 0);
  localparam logic [CNT_W-1:0] TRFC_LAST  = CNT_W'((TRFC_CYC >= 2) ? TRFC_CYC - 2 : 0);
  localparam logic [CNT_W-1:0] TMRD_LAST  = CNT_W'((TMRD_CYC >= 2) ? TMRD_CYC - 2 : 0);
  localparam logic [RC_W-1:0]  RI_LAST    = RC_W'(REF_INTERVAL - 1);
  localparam logic [IC_W-1:0]  INIT_N     = IC_W'(INIT_REF);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;

  typedef enum logic [3:0] {
    S_PWRUP,
    S_PRE,
    S_W_TRP,
    S_AREF,
    S_W_TRFC,
    S_LMR,
    S_W_TMRD,
    S_IDLE,
    S_W_RFC
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IC_W-1:0]   init_cnt_q, init_cnt_d;
  logic [RC_W-1:0]   ref_cnt_q;
  logic [2:0]        pending_q;
  logic [3:0]        cmd_d;
  logic [12:0]       addr_d;
  logic              own_d;
  logic              take;
  logic              tick;
  logic              ovf_set;

  function automatic logic [2:0] pending_next(input logic [2:0] cur, input logic inc,
                                              input logic dec);
    if (inc && !dec) return (cur == 3'd7) ? cur : cur + 3'd1;
    if (dec && !inc) return cur - 3'd1;
    return cur;
  endfunction

  assign take    = ref_req & ref_gnt & (state_q == S_IDLE);
  assign tick    = sdr_init_done & (ref_cnt_q == RI_LAST);
  assign ovf_set = tick & ~take & (pending_q == 3'd7);

  always_ff @(posedge sdram_clk) begin
    if (sdram_reset) begin
      state_q    <= S_PWRUP;
      cnt_q      <= '0;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    init_cnt_d = init_cnt_q;
    cmd_d      = CMD_NOP;
    addr_d     = '0;
    own_d      = 1'b1;
    case (state_q)
      S_PWRUP: begin
        if (cnt_q == PWRUP_LAST) state_d = S_PRE;
      end
      S_PRE: begin
        cmd_d   = CMD_PRE;
        addr_d  = 13'h0400;
        cnt_d   = '0;
        state_d = (TRP_CYC == 1) ? S_AREF : S_W_TRP;
      end
      S_W_TRP: begin
        if (cnt_q == TRP_LAST) state_d = S_AREF;
      end
      S_AREF: begin
        cmd_d      = CMD_AREF;
        cnt_d      = '0;
        init_cnt_d = init_cnt_q + IC_W'(1);
        if (TRFC_CYC == 1) state_d = ((init_cnt_q + IC_W'(1)) < INIT_N) ? S_AREF : S_LMR;
        else               state_d = S_W_TRFC;
      end
      S_W_TRFC: begin
        if (cnt_q == TRFC_LAST) state_d = (init_cnt_q < INIT_N) ? S_AREF : S_LMR;
      end
      S_LMR: begin
        cmd_d   = CMD_LMR;
        addr_d  = MODE_REG;
        cnt_d   = '0;
        state_d = (TMRD_CYC == 1) ? S_IDLE : S_W_TMRD;
      end
      S_W_TMRD: begin
        if (cnt_q == TMRD_LAST) state_d = S_IDLE;
      end
      S_IDLE: begin
        // Refresh AREF goes out on the very edge that samples the grant.
        own_d = 1'b0;
        cnt_d = '0;
        if (take) begin
          cmd_d   = CMD_AREF;
          own_d   = 1'b1;
          state_d = (TRFC_CYC == 1) ? S_IDLE : S_W_RFC;
        end
      end
      S_W_RFC: begin
        if (cnt_q == TRFC_LAST) state_d = S_IDLE;
      end
      default: begin
        state_d = S_PWRUP;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sdram_clk) begin
    if (sdram_reset) begin
      sdr_cke       <= 1'b0;
      {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= 4'b1111;
      sdr_ba        <= 2'b00;
      sdr_addr      <= '0;
      cmd_own       <= 1'b1;
      ref_req       <= 1'b0;
      sdr_init_done <= 1'b0;
      ref_overflow  <= 1'b0;
      pending_q     <= '0;
      ref_cnt_q     <= '0;
    end else begin
      sdr_cke       <= 1'b1;
      {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= cmd_d;
      sdr_ba        <= 2'b00;
      sdr_addr      <= addr_d;
      cmd_own       <= own_d;
      ref_req       <= (state_q == S_IDLE) & (pending_q != 3'd0) & ~take;
      sdr_init_done <= sdr_init_done | (state_q == S_IDLE);
      ref_overflow  <= ref_overflow | ovf_set;
      pending_q     <= pending_next(pending_q, tick, take);
      if (sdr_init_done) ref_cnt_q <= tick ? '0 : ref_cnt_q + RC_W'(1);
    end
  end

endmodule

// File: tb/tb_sdrc_init_refresh_seq.sv
// Bench for sdrc_init_refresh_seq: directed phases with randomized grants,
// every cycle compared against a schedule-level reference model.
module tb_sdrc_init_refresh_seq;

  localparam int P      = 20;
  localparam int TRP    = 3;
  localparam int TRFC   = 7;
  localparam int TMRD   = 2;
  localparam int NREF   = 2;
  localparam int RI     = 50;
  localparam logic [12:0] MR = 13'h033;

  // Init schedule in cycles after reset release.
  localparam int T_PRE   = P;
  localparam int T_AREF0 = P + TRP;
  localparam int T_LMR   = P + TRP + NREF * TRFC;
  localparam int T_DONE  = T_LMR + TMRD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gnt = 1'b0;
  logic        ref_req, cmd_own, sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
  logic [1:0]  sdr_ba;
  logic [12:0] sdr_addr;
  logic        sdr_init_done, ref_overflow;

  always #5 clk = ~clk;

  sdrc_init_refresh_seq #(
    .PWR_UP_CYC(P), .TRP_CYC(TRP), .TRFC_CYC(TRFC), .TMRD_CYC(TMRD),
    .INIT_REF(NREF), .REF_INTERVAL(RI), .MODE_REG(MR)
  ) dut (
    .sdram_clk(clk), .sdram_reset(rst), .ref_gnt(gnt),
    .ref_req(ref_req), .cmd_own(cmd_own), .sdr_cke(sdr_cke),
    .sdr_cs_n(sdr_cs_n), .sdr_ras_n(sdr_ras_n), .sdr_cas_n(sdr_cas_n), .sdr_we_n(sdr_we_n),
    .sdr_ba(sdr_ba), .sdr_addr(sdr_addr), .sdr_init_done(sdr_init_done),
    .ref_overflow(ref_overflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int cyc = 0;
  int pend = 0;
  bit ovf = 1'b0;
  bit req = 1'b0;
  int last_aref = -1000;
  int last_dut_aref = -1000;
  int model_takes = 0;
  int dut_arefs = 0;

  function automatic bit is_tick(input int c);
    return (c > T_DONE) && (((c - T_DONE) % RI) == 0);
  endfunction

  task automatic step();
    bit          take;
    bit          tk;
    bit          own;
    bit          new_req;
    bit   [3:0]  cmd;
    bit   [12:0] addr;
    logic [19:0] exp_pins;
    logic [3:0]  exp_ctl;
    logic [19:0] got_pins;
    logic [3:0]  got_ctl;
    int          c;
    @(posedge clk);
    c = cyc;
    if (rst) begin
      cyc = 0; pend = 0; ovf = 1'b0; req = 1'b0; last_aref = -1000; last_dut_aref = -1000;
      exp_pins = {1'b0, 4'b1111, 2'b00, 13'h0};
      exp_ctl  = 4'b1000;
    end else begin
      take = req && gnt;
      tk   = is_tick(c);
      cmd  = 4'b0111;
      addr = 13'h0;
      if (c < T_DONE) begin
        own = 1'b1;
        if (c == T_PRE) begin cmd = 4'b0010; addr = 13'h0400; end
        else if (c == T_LMR) begin cmd = 4'b0000; addr = MR; end
        else if (c >= T_AREF0 && c < T_LMR && ((c - T_AREF0) % TRFC) == 0) cmd = 4'b0001;
      end else begin
        if (take) cmd = 4'b0001;
        own = take || (c < last_aref + TRFC);
      end
      new_req = (c >= T_DONE) && (c >= last_aref + TRFC) && !take && (pend != 0);
      if (take) begin last_aref = c; model_takes++; end
      if (tk && !take) begin
        if (pend == 7) ovf = 1'b1;
        else pend++;
      end else if (take && !tk) pend--;
      req = new_req;
      exp_pins = {1'b1, cmd, 2'b00, addr};
      exp_ctl  = {own, (c >= T_DONE), req, ovf};
      cyc++;
    end
    #1;
    got_pins = {sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr};
    got_ctl  = {cmd_own, sdr_init_done, ref_req, ref_overflow};
    checks++;
    assert (got_pins === exp_pins) else begin
      errors++;
      $error("FAIL pins c=%0d rst=%0b got %h expected %h", c, rst, got_pins, exp_pins);
    end
    checks++;
    assert (got_ctl === exp_ctl) else begin
      errors++;
      $error("FAIL own/done/req/ovf c=%0d rst=%0b got %b expected %b", c, rst, got_ctl, exp_ctl);
    end
    if (!rst && c > T_DONE && {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} == 4'b0001) begin
      dut_arefs++;
      checks++;
      assert (c - last_dut_aref >= TRFC + 1) else begin
        errors++;
        $error("FAIL aref_gap c=%0d got %0d expected >=%0d", c, c - last_dut_aref, TRFC + 1);
      end
      last_dut_aref = c;
    end
  endtask

  initial begin
    // Reset values
    rst = 1'b1; gnt = 1'b0;
    repeat (3) step();

    // Start init with random grant noise, then reset mid-init at cycle 25
    rst = 1'b0;
    repeat (25) begin gnt = 1'($urandom_range(0, 1)); step(); end
    rst = 1'b1;
    repeat (2) begin gnt = 1'($urandom_range(0, 1)); step(); end

    // Full init with grant noise
    rst = 1'b0;
    repeat (T_DONE + 5) begin gnt = 1'($urandom_range(0, 1)); step(); end

    // Grant tied high: one refresh per interval
    gnt = 1'b1;
    repeat (160) step();

    // Starve the scheduler until the pending count saturates
    gnt = 1'b0;
    repeat (400) step();
    checks++;
    assert (ref_overflow === 1'b1) else begin
      errors++;
      $error("FAIL overflow_sticky got %b expected 1", ref_overflow);
    end

    // Drain the backlog
    model_takes = 0; dut_arefs = 0;
    gnt = 1'b1;
    repeat (120) step();
    checks++;
    assert (dut_arefs === model_takes && model_takes >= 7) else begin
      errors++;
      $error("FAIL drain_arefs got %0d expected %0d (>=7)", dut_arefs, model_takes);
    end

    // Make a grant land on the same edge as a tick while one refresh is pending
    gnt = 1'b1;
    while (!is_tick(cyc)) step();
    step();
    gnt = 1'b0;
    while (!is_tick(cyc)) step();
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    repeat (TRFC + 3) step();
    checks++;
    assert (ref_req === 1'b1 && cmd_own === 1'b0) else begin
      errors++;
      $error("FAIL req_after_coincide got req=%b own=%b expected req=1 own=0", ref_req, cmd_own);
    end

    // Random grant traffic
    repeat (1000) begin gnt = ($urandom_range(0, 9) < 3); step(); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
